// File: rtl/pulse_train_scheduler_pkg.sv
// Shared definitions for the two-requester pulse train scheduler.
package pulse_train_scheduler_pkg;

  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned NUM_W_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DELAY = 3'd1,
    ST_HIGH  = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/pulse_train_scheduler_rr_arbiter2.sv
// Two-way round-robin winner select; the priority pointer lives in the parent.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,   // 1: requester 1 has priority on a tie
  input  logic       en_i,
  output logic [1:0] win_o
);

  always_comb begin
    win_o = '0;
    if (en_i) begin
      case (req_i)
        2'b01:   win_o = 2'b01;
        2'b10:   win_o = 2'b10;
        2'b11:   win_o = ptr_i ? 2'b10 : 2'b01;
        default: win_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/pulse_train_scheduler.sv
// Arbitrates two requesters onto one shared line and plays a clock-counted
// pulse train (delay, then N pulses of width/gap) for the granted one.
module pulse_train_scheduler
  import pulse_train_scheduler_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned NUM_W = NUM_W_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [1:0]       req,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_gap,
  input  logic [NUM_W-1:0] cfg_num,
  output logic [1:0]       grant,
  output logic             busy,
  output logic             signal,
  output logic [1:0]       done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [NUM_W-1:0] pcnt_q, pcnt_d;
  logic             gsel_q, gsel_d;
  logic             ptr_q, ptr_d;
  logic [1:0]       grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             signal_q, signal_d;
  logic [1:0]       done_q, done_d;
  logic [1:0]       win;
  logic             abort;

  function automatic logic [CNT_W-1:0] load_len(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  rr_arbiter2 u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .en_i  ((state_q == ST_IDLE) && !busy_q),
    .win_o (win)
  );

  assign abort = (state_q == ST_DELAY || state_q == ST_HIGH || state_q == ST_GAP)
                 && !req[gsel_q];

  // signal and done follow the FSM one cycle later; grant/busy are held through
  // that extra DONE cycle, which also forces one dead IDLE cycle between trains.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    width_d  = width_q;
    gap_d    = gap_q;
    pcnt_d   = pcnt_q;
    gsel_d   = gsel_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    busy_d   = busy_q;
    signal_d = (state_q == ST_HIGH);
    done_d   = '0;

    if (done_q != '0) begin
      grant_d = '0;
      busy_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (win != '0) begin
          grant_d = win;
          gsel_d  = win[1];
          ptr_d   = win[0];
          busy_d  = 1'b1;
          width_d = cfg_width;
          gap_d   = cfg_gap;
          pcnt_d  = (cfg_num == '0) ? NUM_W'(1) : cfg_num;
          if (cfg_delay != '0) begin
            state_d = ST_DELAY;
            cnt_d   = cfg_delay - 1'b1;
          end else begin
            state_d = ST_HIGH;
            cnt_d   = load_len(cfg_width);
          end
        end
      end
      ST_DELAY: begin
        if (cnt_q == '0) begin
          state_d = ST_HIGH;
          cnt_d   = load_len(width_q);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HIGH: begin
        if (cnt_q == '0) begin
          pcnt_d = pcnt_q - 1'b1;
          if (pcnt_q > NUM_W'(1)) begin
            state_d = ST_GAP;
            cnt_d   = load_len(gap_q);
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_HIGH;
          cnt_d   = load_len(width_q);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = grant_q;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      signal_d = 1'b0;
      grant_d  = '0;
      busy_d   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      width_q  <= '0;
      gap_q    <= '0;
      pcnt_q   <= '0;
      gsel_q   <= 1'b0;
      ptr_q    <= 1'b0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      signal_q <= 1'b0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      width_q  <= width_d;
      gap_q    <= gap_d;
      pcnt_q   <= pcnt_d;
      gsel_q   <= gsel_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      signal_q <= signal_d;
      done_q   <= done_d;
    end
  end

  assign grant  = grant_q;
  assign busy   = busy_q;
  assign signal = signal_q;
  assign done   = done_q;

endmodule

// File: tb/tb_pulse_train_scheduler.sv
// Directed bench for pulse_train_scheduler; E denotes the edge where grant rises.
module tb_pulse_train_scheduler;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] req;
  logic [7:0] cfg_delay, cfg_width, cfg_gap;
  logic [3:0] cfg_num;
  logic [1:0] grant;
  logic       busy;
  logic       signal;
  logic [1:0] done;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  pulse_train_scheduler #(.CNT_W(8), .NUM_W(4)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .cfg_delay (cfg_delay),
    .cfg_width (cfg_width),
    .cfg_gap   (cfg_gap),
    .cfg_num   (cfg_num),
    .grant     (grant),
    .busy      (busy),
    .signal    (signal),
    .done      (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_cfg(input logic [7:0] d, input logic [7:0] w, input logic [7:0] g,
                         input logic [3:0] n);
    cfg_delay = d;
    cfg_width = w;
    cfg_gap   = g;
    cfg_num   = n;
  endtask

  // Cycles k0..k1 after E: signal must equal mask[k], done must be dv only at k==dk.
  task automatic watch(input int k0, input int k1, input logic [31:0] mask,
                       input int dk, input logic [1:0] dv);
    for (int k = k0; k <= k1; k++) begin
      step();
      check($sformatf("signal@E+%0d", k), {31'd0, signal}, {31'd0, mask[k]});
      check($sformatf("done@E+%0d", k), {30'd0, done}, (k == dk) ? {30'd0, dv} : 32'd0);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    req     = '0;
    set_cfg(8'd0, 8'd0, 8'd0, 4'd0);
    #1;
    check("rst_grant",  {30'd0, grant}, 32'd0);
    check("rst_busy",   {31'd0, busy},  32'd0);
    check("rst_signal", {31'd0, signal}, 32'd0);
    check("rst_done",   {30'd0, done},  32'd0);
    #11 reset_n = 1'b1;

    // Contest with both requesting continuously: 01, 10, 01
    req = 2'b11;
    set_cfg(8'd0, 8'd1, 8'd0, 4'd1);
    for (int t = 0; t < 3; t++) begin
      logic [1:0] exp_g;
      exp_g = (t == 1) ? 2'b10 : 2'b01;
      step();
      check($sformatf("rr_grant%0d", t), {30'd0, grant}, {30'd0, exp_g});
      step();
      check($sformatf("rr_signal%0d", t), {31'd0, signal}, 32'd1);
      step();
      check($sformatf("rr_done%0d", t), {30'd0, done}, {30'd0, exp_g});
      if (t == 2) req = 2'b00;
      step();
      check($sformatf("rr_dead%0d", t), {30'd0, grant}, 32'd0);
    end

    // Single requester: delay 3, width 2, gap 1, three pulses
    set_cfg(8'd3, 8'd2, 8'd1, 4'd3);
    req = 2'b01;
    step();
    check("single_grant", {30'd0, grant}, 32'd1);
    check("single_busy",  {31'd0, busy},  32'd1);
    watch(1, 12, 32'h0000_0DB0, 12, 2'b01);
    check("single_grant_done", {30'd0, grant}, 32'd1);
    req = 2'b00;
    step();
    check("single_grant_end", {30'd0, grant}, 32'd0);
    check("single_busy_end",  {31'd0, busy},  32'd0);

    // All-zero config: one single-cycle pulse
    set_cfg(8'd0, 8'd0, 8'd0, 4'd0);
    req = 2'b01;
    step();
    check("zero_grant", {30'd0, grant}, 32'd1);
    watch(1, 2, 32'h0000_0002, 2, 2'b01);
    req = 2'b00;
    step();
    check("zero_grant_end", {30'd0, grant}, 32'd0);

    // Abort requester 1 during GAP of a 4-pulse train
    set_cfg(8'd0, 8'd2, 8'd3, 4'd4);
    req = 2'b10;
    step();
    check("abort_grant", {30'd0, grant}, 32'd2);
    step();
    check("abort_pulse", {31'd0, signal}, 32'd1);
    step();
    step();
    req = 2'b00;
    step();
    check("abort_signal", {31'd0, signal}, 32'd0);
    check("abort_grant0", {30'd0, grant},  32'd0);
    check("abort_busy",   {31'd0, busy},   32'd0);
    check("abort_nodone", {30'd0, done},   32'd0);
    step();
    check("abort_nodone2", {30'd0, done}, 32'd0);
    set_cfg(8'd0, 8'd1, 8'd0, 4'd1);
    req = 2'b11;
    step();
    check("abort_next_grant", {30'd0, grant}, 32'd1);
    step();
    step();
    check("abort_next_done", {30'd0, done}, 32'd1);
    req = 2'b00;
    step();

    // Width changed from 5 to 1 mid-train has no effect
    set_cfg(8'd0, 8'd5, 8'd1, 4'd2);
    req = 2'b01;
    step();
    check("cfg_grant", {30'd0, grant}, 32'd1);
    watch(1, 2, 32'h0000_0FBE, 12, 2'b01);
    cfg_width = 8'd1;
    watch(3, 12, 32'h0000_0FBE, 12, 2'b01);
    req = 2'b00;
    step();
    check("cfg_grant_end", {30'd0, grant}, 32'd0);

    // Maximum delay of 255: first pulse at E+256
    set_cfg(8'd255, 8'd1, 8'd0, 4'd1);
    req = 2'b01;
    step();
    check("maxd_grant", {30'd0, grant}, 32'd1);
    repeat (255) step();
    check("maxd_sig255",  {31'd0, signal}, 32'd0);
    check("maxd_busy255", {31'd0, busy},   32'd1);
    step();
    check("maxd_sig256", {31'd0, signal}, 32'd1);
    step();
    check("maxd_sig257",  {31'd0, signal}, 32'd0);
    check("maxd_done257", {30'd0, done},   32'd1);
    req = 2'b00;
    step();

    // Asynchronous reset while HIGH, then req[0] wins the first contest
    set_cfg(8'd0, 8'd10, 8'd0, 4'd1);
    req = 2'b01;
    step();
    step();
    step();
    step();
    check("mid_signal_pre", {31'd0, signal}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_signal", {31'd0, signal}, 32'd0);
    check("mid_rst_grant",  {30'd0, grant},  32'd0);
    check("mid_rst_busy",   {31'd0, busy},   32'd0);
    check("mid_rst_done",   {30'd0, done},   32'd0);
    #2 reset_n = 1'b1;
    set_cfg(8'd0, 8'd1, 8'd0, 4'd1);
    req = 2'b11;
    step();
    check("post_rst_grant", {30'd0, grant}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pulse_train_scheduler.md
Name: pulse_train_scheduler

Overview:
- Shares one pulse/trigger output between two requesters.
- Round-robin arbiter plus a sequencer FSM that generates the pulse train for the granted requester: programmable delay, then N pulses of programmable high width separated by a programmable gap.
- Replaces free-running "#delay" pulse/trigger behaviour with synthesizable, clock-counted sequencing.
- Sits between test-stimulus requesters and the shared signal line.

Parameters:
CNT_W, 8, width of the delay, width and gap cycle counters
NUM_W, 4, width of the pulse-count field

Ports:
clock  in  1  single system clock; all state updates on its rising edge
reset_n  in  1  asynchronous, active-low reset
req  in  2  request lines, one per requester; level-sensitive; held until done or dropped to abort
cfg_delay  in  CNT_W  cycles from grant to first pulse; sampled at grant
cfg_width  in  CNT_W  high cycles per pulse; sampled at grant
cfg_gap  in  CNT_W  low cycles between pulses; sampled at grant
cfg_num  in  NUM_W  pulses per train; sampled at grant
grant  out  2  one-hot grant; all-zero when idle
busy  out  1  high while any state other than IDLE
signal  out  1  shared pulse output, registered
done  out  2  one-cycle completion strobe for the granted requester

Behaviour:
- Reset (reset_n low, asynchronous):
  - FSM to IDLE; grant=0, busy=0, signal=0, done=0.
  - All counters 0; round-robin pointer set so req[0] wins the first contest.
- States: IDLE, DELAY, HIGH, GAP, DONE.
- IDLE:
  - On an edge where req!=0, grant the winner (one-hot).
  - Latch cfg_* into internal registers; busy=1.
  - Next state is DELAY if cfg_delay>0, else HIGH.
- Arbitration:
  - Single request: that requester wins.
  - Both requesting: the requester not granted last wins.
  - Pointer updates only at grant.
- DELAY:
  - Lasts exactly delay cycles, then HIGH.
  - First signal high edge = grant edge + delay + 1.
- HIGH:
  - signal=1 for max(width,1) cycles.
  - Then GAP if pulses remaining > 1, else DONE.
- GAP:
  - signal=0 for max(gap,1) cycles, then HIGH.
- Pulse count:
  - cfg_num=0 is treated as 1.
  - The pulse counter decrements on each HIGH exit.
- DONE:
  - One cycle: signal=0, done[g]=1, grant still held.
  - Next edge: grant=0, busy=0, state IDLE.
  - A new grant requires at least one IDLE cycle: minimum one dead cycle between trains.
  - A requester must deassert req within the DONE cycle or it re-competes.
- Abort:
  - If req[g] of the granted requester is low on any edge in DELAY, HIGH or GAP, go to IDLE.
  - On that edge: signal=0, grant=0, busy=0, no done strobe.
  - The pointer still counts that grant as served.
- Config stability: cfg_* changes after grant have no effect on the running train.
- Non-granted requester: its req is ignored until IDLE; no preemption.
- Counter boundaries:
  - Counters load value-1 and count down to 0; no wrap.
  - A maximum value of 2^CNT_W-1 cycles is supported exactly.
- Outputs: all outputs are registered; none is combinational from req or cfg.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=0, DELAY=1, HIGH=2, GAP=3, DONE=4; 3-bit);
  - default CNT_W and NUM_W.
- One natural sub-module: rr_arbiter2.
  - Inputs: req[1:0], pointer, enable.
  - Output: one-hot winner.
  - Pointer update is kept in the parent.
- Counters and FSM stay in the parent module.

Test Plan:
- Reset mid-train: assert reset_n=0 during HIGH -> signal, grant, busy and done all 0 immediately (asynchronous, no clock needed); after release, first grant goes to req[0].
- Single requester: req=01, delay=3, width=2, gap=1, num=3.
  - grant=01 at edge E.
  - signal high on E+4..E+5, E+7..E+8, E+10..E+11.
  - done[0] at E+12; grant=0 at E+13.
- Simultaneous contest: req=11 held continuously, delay=0, width=1, num=1 -> grants alternate 01, 10, 01 with one IDLE cycle between trains; done strobes match the grant each time.
- Zero-value config: delay=0, width=0, gap=0, num=0 -> exactly one pulse, one cycle high, on E+1; done at E+2.
- Abort: requester 1 granted; req[1] dropped in GAP of a 4-pulse train -> signal=0 and grant=0 on the next edge, no done; the following contest with req=11 goes to requester 0.
- Config change: cfg_width changed from 5 to 1 two cycles after grant -> all pulses stay 5 cycles wide; max delay of 255 with CNT_W=8 -> first pulse at E+256.
